interrupt_dispatch_sequencer: RTL and testbench

- Stack-push counterpart of the return/RETI pop path. At an instruction boundary it takes a pending, enabled interrupt and runs the 5 M-cycle dispatch: it pushes PC, clears IME, acknowledges the IF bit and loads PC with the vector.
- It sits beside the control unit's microcode blocks. It requests the same register-file and bus actions: SP decrement, SP as address, PC byte onto the data bus, PC load.
- It owns its own M-cycle state machine; it is not driven by the shared cycle counter.

---
 rtl/interrupt_dispatch_sequencer_pkg.sv | 27 ++
 rtl/interrupt_dispatch_sequencer_priority_encoder.sv | 22 ++
 rtl/interrupt_dispatch_sequencer.sv | 108 ++++++++++
 tb/tb_interrupt_dispatch_sequencer.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/interrupt_dispatch_sequencer_pkg.sv
// Shared control definitions for the interrupt dispatch path.
package interrupt_dispatch_sequencer_pkg;

  localparam int INT_W = 5;
  localparam int IDX_W = 3;

  // Interrupt bit indices; a lower index means higher priority
  localparam int VBLANK = 0;
  localparam int STAT   = 1;
  localparam int TIMER  = 2;
  localparam int SERIAL = 3;
  localparam int JOYPAD = 4;

  localparam logic [15:0] DEF_VECTOR_BASE   = 16'h0040;
  localparam logic [15:0] DEF_VECTOR_STRIDE = 16'd8;

  // Dispatch M-cycle states
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WAIT    = 3'd1,
    ST_SP_DEC  = 3'd2,
    ST_PUSH_HI = 3'd3,
    ST_PUSH_LO = 3'd4,
    ST_LOAD_PC = 3'd5
  } state_t;

endpackage

// File: rtl/interrupt_dispatch_sequencer_priority_encoder.sv
// Lowest-set-bit encoder over the masked interrupt request; shared with HALT wake.
module interrupt_priority_encoder
  import interrupt_dispatch_sequencer_pkg::*;
(
  input  logic [INT_W-1:0] req,
  output logic [IDX_W-1:0] idx,
  output logic             vld
);

  // Scan from the lowest-priority bit up so the lowest set bit is written last
  always_comb begin
    idx = '0;
    vld = 1'b0;
    for (int i = INT_W - 1; i >= 0; i--) begin
      if (req[i]) begin
        idx = IDX_W'(i);
        vld = 1'b1;
      end
    end
  end

endmodule

// File: rtl/interrupt_dispatch_sequencer.sv
// Five M-cycle interrupt dispatch: push PC, clear IME, acknowledge IF, jump to vector.
module interrupt_dispatch_sequencer
  import interrupt_dispatch_sequencer_pkg::*;
#(
  parameter logic [15:0] VECTOR_BASE   = DEF_VECTOR_BASE,
  parameter logic [15:0] VECTOR_STRIDE = DEF_VECTOR_STRIDE
) (
  input  logic             i_Clk,
  input  logic             i_Reset,
  input  logic             i_M_Tick,
  input  logic             i_Boundary,
  input  logic             i_IME,
  input  logic [INT_W-1:0] i_IE,
  input  logic [INT_W-1:0] i_IF,
  output logic             o_Busy,
  output logic             o_IME_Clear,
  output logic             o_SP_Decrement,
  output logic             o_Address_Out,
  output logic             o_Bus_Out,
  output logic             o_PC_Byte_Sel,
  output logic             o_PC_Load,
  output logic [15:0]      o_PC_Vector,
  output logic [INT_W-1:0] o_IF_Clear
);

  state_t           state;
  logic [IDX_W-1:0] sel_idx;
  logic             sel_vld;
  logic [IDX_W-1:0] enc_idx;
  logic             enc_vld;
  logic             entry;

  interrupt_priority_encoder u_prio (
    .req (i_IE & i_IF),
    .idx (enc_idx),
    .vld (enc_vld)
  );

  assign entry = i_IME & i_Boundary & enc_vld;

  // M-cycle sequencer; selection is frozen at the PUSH_HI tick because the
  // high-byte push may land on IE and cancel the dispatch
  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      state   <= ST_IDLE;
      sel_idx <= '0;
      sel_vld <= 1'b0;
    end else if (i_M_Tick) begin
      case (state)
        ST_IDLE:    if (entry) state <= ST_WAIT;
        ST_WAIT:    state <= ST_SP_DEC;
        ST_SP_DEC:  state <= ST_PUSH_HI;
        ST_PUSH_HI: begin
          sel_idx <= enc_idx;
          sel_vld <= enc_vld;
          state   <= ST_PUSH_LO;
        end
        ST_PUSH_LO: state <= ST_LOAD_PC;
        default:    state <= ST_IDLE;
      endcase
    end
  end

  // Output decode from registered state only, so outputs hold for the whole M-cycle
  always_comb begin
    o_Busy         = 1'b0;
    o_IME_Clear    = 1'b0;
    o_SP_Decrement = 1'b0;
    o_Address_Out  = 1'b0;
    o_Bus_Out      = 1'b0;
    o_PC_Byte_Sel  = 1'b0;
    o_PC_Load      = 1'b0;
    o_PC_Vector    = 16'h0000;
    o_IF_Clear     = '0;
    case (state)
      ST_WAIT: begin
        o_Busy      = 1'b1;
        o_IME_Clear = 1'b1;
      end
      ST_SP_DEC: begin
        o_Busy         = 1'b1;
        o_SP_Decrement = 1'b1;
      end
      ST_PUSH_HI: begin
        o_Busy         = 1'b1;
        o_SP_Decrement = 1'b1;
        o_Address_Out  = 1'b1;
        o_Bus_Out      = 1'b1;
        o_PC_Byte_Sel  = 1'b1;
      end
      ST_PUSH_LO: begin
        o_Busy        = 1'b1;
        o_Address_Out = 1'b1;
        o_Bus_Out     = 1'b1;
      end
      ST_LOAD_PC: begin
        o_Busy    = 1'b1;
        o_PC_Load = 1'b1;
        if (sel_vld) begin
          o_PC_Vector = VECTOR_BASE + 16'(sel_idx) * VECTOR_STRIDE;
          o_IF_Clear  = INT_W'(1) << sel_idx;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_interrupt_dispatch_sequencer.sv
// Directed and randomized checks of the interrupt dispatch sequencer against a table model.
module tb_interrupt_dispatch_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        m_tick;
  logic        bnd;
  logic        ime;
  logic [4:0]  ie;
  logic [4:0]  ifr;
  logic        busy, ime_clr, sp_dec, addr_out, bus_out, byte_sel, pc_load;
  logic [15:0] vec;
  logic [4:0]  if_clr;
  logic [27:0] outs;
  logic [27:0] cur_exp;
  int          total = 0;
  int          bad = 0;

  always #5 clk = ~clk;

  interrupt_dispatch_sequencer dut (
    .i_Clk          (clk),
    .i_Reset        (rst),
    .i_M_Tick       (m_tick),
    .i_Boundary     (bnd),
    .i_IME          (ime),
    .i_IE           (ie),
    .i_IF           (ifr),
    .o_Busy         (busy),
    .o_IME_Clear    (ime_clr),
    .o_SP_Decrement (sp_dec),
    .o_Address_Out  (addr_out),
    .o_Bus_Out      (bus_out),
    .o_PC_Byte_Sel  (byte_sel),
    .o_PC_Load      (pc_load),
    .o_PC_Vector    (vec),
    .o_IF_Clear     (if_clr)
  );

  assign outs = {busy, ime_clr, sp_dec, addr_out, bus_out, byte_sel, pc_load, vec, if_clr};

  // Expected output bundle for dispatch M-cycle m (0 = idle), given the request
  // (IE & IF) seen at the high-byte push
  function automatic logic [27:0] exp_outs(input int m, input logic [4:0] req);
    logic [4:0]  r;
    int          k;
    logic [15:0] v;
    logic [4:0]  c;
    r = req; k = 0; v = 16'h0000; c = 5'h00;
    if (r != 0) begin
      while (r[0] == 1'b0) begin r = r >> 1; k++; end
      v = 16'h0040 + 16'(k * 8);
      c = 5'(1 << k);
    end
    case (m)
      1: return {7'b1100000, 16'h0000, 5'h00};
      2: return {7'b1010000, 16'h0000, 5'h00};
      3: return {7'b1011110, 16'h0000, 5'h00};
      4: return {7'b1001100, 16'h0000, 5'h00};
      5: return {7'b1000001, v, c};
      default: return 28'h0;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [27:0] exp);
    total++;
    assert (outs === exp) else begin
      bad++;
      $error("FAIL %s got=%h exp=%h", tag, outs, exp);
    end
  endtask

  // One M-cycle: three quiet T-steps (outputs must hold) then the tick T-step
  task automatic mcycle();
    m_tick = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("hold", cur_exp);
    end
    m_tick = 1'b1;
    @(negedge clk);
    m_tick = 1'b0;
  endtask

  task automatic step(input string tag, input int m, input logic [4:0] req);
    mcycle();
    cur_exp = exp_outs(m, req);
    chk(tag, cur_exp);
  endtask

  // Full dispatch; IE/IF may change before the PUSH_HI tick and again after it
  task automatic dispatch(input logic [4:0] ie0, input logic [4:0] if0,
                          input logic [4:0] ie_hi, input logic [4:0] if_hi,
                          input logic [4:0] ie_lt, input logic [4:0] if_lt);
    ie = ie0; ifr = if0; ime = 1'b1; bnd = 1'b1;
    step("wait", 1, 5'h0);
    step("spdec", 2, 5'h0);
    step("pushhi", 3, 5'h0);
    ie = ie_hi; ifr = if_hi;
    step("pushlo", 4, 5'h0);
    ie = ie_lt; ifr = if_lt;
    step("loadpc", 5, ie_hi & if_hi);
    ime = 1'b0;
    step("idle", 0, 5'h0);
    bnd = 1'b0;
  endtask

  initial begin
    logic [4:0] a, b, c, d;
    rst = 1'b1; m_tick = 1'b0; bnd = 1'b0; ime = 1'b0; ie = 5'h0; ifr = 5'h0;
    cur_exp = 28'h0;
    repeat (2) @(negedge clk);
    chk("reset", 28'h0);
    m_tick = 1'b1; ime = 1'b1; bnd = 1'b1; ie = 5'h01; ifr = 5'h01;
    @(negedge clk);
    chk("reset_tick", 28'h0);
    m_tick = 1'b0; ime = 1'b0; bnd = 1'b0;
    rst = 1'b0;

    // Directed plan cases
    dispatch(5'h05, 5'h04, 5'h05, 5'h04, 5'h05, 5'h04);
    dispatch(5'h1F, 5'h1A, 5'h1F, 5'h1A, 5'h1F, 5'h1A);
    dispatch(5'h10, 5'h10, 5'h00, 5'h10, 5'h00, 5'h10);
    dispatch(5'h01, 5'h01, 5'h01, 5'h01, 5'h01, 5'h1F);

    // IME low: no entry
    ime = 1'b0; bnd = 1'b1; ie = 5'h01; ifr = 5'h01;
    repeat (3) step("ime_off", 0, 5'h0);
    // Not at a boundary: no entry
    ime = 1'b1; bnd = 1'b0;
    repeat (2) step("no_bnd", 0, 5'h0);
    // Entry condition present but no tick: state holds
    bnd = 1'b1;
    repeat (20) begin
      @(negedge clk);
      chk("no_tick", 28'h0);
    end
    ime = 1'b0; bnd = 1'b0;

    // Reset during PUSH_LO aborts the dispatch
    ie = 5'h04; ifr = 5'h04; ime = 1'b1; bnd = 1'b1;
    step("r_wait", 1, 5'h0);
    ime = 1'b0;
    step("r_spdec", 2, 5'h0);
    step("r_pushhi", 3, 5'h0);
    step("r_pushlo", 4, 5'h0);
    rst = 1'b1;
    @(negedge clk);
    cur_exp = 28'h0;
    chk("r_abort", cur_exp);
    rst = 1'b0;
    bnd = 1'b0;
    repeat (3) step("r_idle", 0, 5'h0);
    dispatch(5'h02, 5'h03, 5'h02, 5'h03, 5'h02, 5'h03);

    // Randomized dispatches, including cancellations and late changes
    for (int n = 0; n < 40; n++) begin
      a = 5'($urandom);
      b = 5'($urandom) | (5'h01 << $urandom_range(0, 4));
      a = a | b & (5'h01 << $urandom_range(0, 4));
      if ((a & b) == 5'h0) a = b;
      c = ($urandom_range(0, 3) == 0) ? 5'h00 : 5'($urandom);
      d = 5'($urandom);
      dispatch(a, b, c, d, 5'($urandom), 5'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
